// File: rtl/ram_dma_pkg.sv
// Shared types and sizes for the RAM block-copy engine.
// Holds the FSM state enum and the default RAM geometry.
package ram_dma_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 64;
    localparam int MAX_LEN = 256;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/ram_dma_copier.sv
// Block copy engine driving a single-port RAM (read, capture, write per word).
// Ports: clk, rst (async, high), start/src_addr/dst_addr/len request,
//   busy/done/checksum status, cen/wen/s_addr/s_din/s_dout RAM port.
// Optional: define RAM_DMA_CHECKSUM_EN to build the XOR checksum accumulator.
module ram_dma_copier #(
    parameter int ADDR_W = ram_dma_pkg::ADDR_W,
    parameter int DATA_W = ram_dma_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              cen,
    output logic              wen,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_din,
    input  logic [DATA_W-1:0] s_dout
);
    import ram_dma_pkg::*;

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_LEN);

    state_t            state;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   idx_nxt;
    logic [ADDR_W:0]   len_c;

    assign len_c   = (len > MAX_CNT) ? MAX_CNT : len;
    assign idx_nxt = idx + 1'b1;

    // Outputs are registered for the state being entered, so every
    // RAM-port value comes straight from a flop.  s_din doubles as
    // the word buffer between CAPT and WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            src    <= '0;
            dst    <= '0;
            cnt    <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cen    <= 1'b0;
            wen    <= 1'b0;
            s_addr <= '0;
            s_din  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        src  <= src_addr;
                        dst  <= dst_addr;
                        cnt  <= len_c;
                        idx  <= '0;
                        busy <= 1'b1;
                        if (len_c == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= READ;
                            cen    <= 1'b1;
                            wen    <= 1'b0;
                            s_addr <= src_addr;
                        end
                    end
                end
                READ: begin
                    state  <= CAPT;
                    cen    <= 1'b0;
                    s_addr <= '0;
                end
                CAPT: begin
                    state  <= WRITE;
                    cen    <= 1'b1;
                    wen    <= 1'b1;
                    s_addr <= dst + idx[ADDR_W-1:0];
                    s_din  <= s_dout;
                end
                WRITE: begin
                    idx   <= idx_nxt;
                    wen   <= 1'b0;
                    s_din <= '0;
                    if (idx_nxt == cnt) begin
                        state  <= DONE;
                        cen    <= 1'b0;
                        s_addr <= '0;
                        done   <= 1'b1;
                    end else begin
                        state  <= READ;
                        cen    <= 1'b1;
                        s_addr <= src + idx_nxt[ADDR_W-1:0];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RAM_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            csum <= '0;
        else if (state == IDLE && start)
            csum <= '0;
        else if (state == CAPT)
            csum <= csum ^ s_dout;
    end

    assign checksum = csum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_dma_copier.sv
// Self-checking bench for ram_dma_copier with a behavioural RAM.
// A word-by-word copy model checks the RAM port every cycle.
module tb_ram_dma_copier;

`ifdef RAM_DMA_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  src_addr = '0;
    logic [7:0]  dst_addr = '0;
    logic [8:0]  len = '0;
    logic        busy;
    logic        done;
    logic [63:0] checksum;
    logic        cen;
    logic        wen;
    logic [7:0]  s_addr;
    logic [63:0] s_din;
    logic [63:0] s_dout = '0;

    logic [63:0] mem [256];
    logic [63:0] gm  [256];

    int n_chk  = 0;
    int n_pass = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int cen_cnt  = 0;
    logic [63:0] ck_done;

    ram_dma_copier dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .checksum (checksum),
        .cen      (cen),
        .wen      (wen),
        .s_addr   (s_addr),
        .s_din    (s_din),
        .s_dout   (s_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cen && wen)
            mem[s_addr] <= s_din;
        else if (cen)
            s_dout <= mem[s_addr];
        else
            s_dout <= '0;
    end

    task automatic chk(input string nm,
                       input logic [63:0] a,
                       input logic [63:0] e);
        n_chk++;
        if (a === e)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     nm, a, e, $time);
    endtask

    // Reference model: copy proceeds one word at a time in ascending
    // order, three cycles per word, then one DONE cycle.
    bit         act = 1'b0;
    int         c = 0;
    int         n = 0;
    logic [7:0] ms, md;
    logic [63:0] m_ck = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (cen)  cen_cnt++;
            if (rst) begin
                act  = 1'b0;
                m_ck = '0;
            end
            if (act) begin
                chk("busy", {63'd0, busy}, 64'd1);
                chk("done", {63'd0, done}, {63'd0, c == 3*n+1});
                if (c == 3*n+1) begin
                    chk("cen_done", {63'd0, cen}, 64'd0);
                    chk("checksum_done", checksum, m_ck);
                end else begin
                    int         i;
                    int         ph;
                    logic [7:0] sa, da;
                    logic [63:0] w;
                    i  = (c-1) / 3;
                    ph = (c-1) % 3;
                    sa = ms + 8'(i);
                    da = md + 8'(i);
                    if (ph == 0) begin
                        chk("rd_cen", {63'd0, cen}, 64'd1);
                        chk("rd_wen", {63'd0, wen}, 64'd0);
                        chk("rd_addr", {56'd0, s_addr}, {56'd0, sa});
                    end else if (ph == 1) begin
                        chk("capt_cen", {63'd0, cen}, 64'd0);
                        chk("capt_wen", {63'd0, wen}, 64'd0);
                    end else begin
                        w = gm[sa];
                        chk("wr_cen", {63'd0, cen}, 64'd1);
                        chk("wr_wen", {63'd0, wen}, 64'd1);
                        chk("wr_addr", {56'd0, s_addr}, {56'd0, da});
                        chk("wr_data", s_din, w);
                        gm[da] = w;
                        if (CK_EN) m_ck = m_ck ^ w;
                    end
                end
            end else begin
                chk("idle_busy", {63'd0, busy}, 64'd0);
                chk("idle_done", {63'd0, done}, 64'd0);
                chk("idle_cen", {63'd0, cen}, 64'd0);
                chk("idle_wen", {63'd0, wen}, 64'd0);
                chk("idle_addr", {56'd0, s_addr}, 64'd0);
                chk("idle_din", s_din, 64'd0);
                chk("idle_checksum", checksum, m_ck);
            end
            if (act) begin
                c++;
                if (c > 3*n+1) act = 1'b0;
            end else if (start && !rst) begin
                act  = 1'b1;
                c    = 1;
                ms   = src_addr;
                md   = dst_addr;
                n    = (len > 9'd256) ? 256 : int'(len);
                m_ck = '0;
            end
        end
    end

    task automatic pre(input logic [7:0] a, input logic [63:0] v);
        mem[a] = v;
        gm[a]  = v;
    endtask

    task automatic memeq(input string nm);
        int bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== gm[i]) bad++;
        chk(nm, 64'(bad), 64'd0);
    endtask

    task automatic kick(input logic [7:0] s, input logic [7:0] d,
                        input logic [8:0] l);
        @(posedge clk); #2;
        busy_cnt = 0;
        done_cnt = 0;
        cen_cnt  = 0;
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        bit got = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                ck_done = checksum;
                break;
            end
        end
        chk("done_seen", {63'd0, got}, 64'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            pre(8'(i), {32'hDEAD_BEEF, 32'(i)});
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_checksum", checksum, 64'd0);

        for (int i = 0; i < 4; i++)
            pre(8'h10 + 8'(i), 64'hA0 + 64'(i));
        kick(8'h10, 8'h80, 9'd4);
        wait_done(50);
        for (int i = 0; i < 4; i++)
            chk("t1_mem", mem[8'h80 + 8'(i)], 64'hA0 + 64'(i));
        chk("t1_busy_cycles", 64'(busy_cnt), 64'd13);
        chk("t1_done_pulses", 64'(done_cnt), 64'd1);
        memeq("t1_mem_all");

        kick(8'h33, 8'h44, 9'd0);
        wait_done(10);
        chk("t2_busy_cycles", 64'(busy_cnt), 64'd1);
        chk("t2_done_pulses", 64'(done_cnt), 64'd1);
        chk("t2_cen_cycles", 64'(cen_cnt), 64'd0);
        memeq("t2_mem_all");

        pre(8'hFE, 64'hB0);
        pre(8'hFF, 64'hB1);
        pre(8'h00, 64'hB2);
        pre(8'h01, 64'hB3);
        kick(8'hFE, 8'h02, 9'd4);
        wait_done(50);
        for (int i = 0; i < 4; i++)
            chk("t3_wrap_mem", mem[8'h02 + 8'(i)], 64'hB0 + 64'(i));
        memeq("t3_mem_all");

        for (int i = 0; i < 8; i++)
            pre(8'h20 + 8'(i), 64'hC0 + 64'(i));
        kick(8'h20, 8'h40, 9'd8);
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_cen", {63'd0, cen}, 64'd0);
        chk("t4_rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #2 rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("t4_no_done", 64'(done_cnt), 64'd0);
        chk("t4_w0", mem[8'h40], 64'hC0);
        chk("t4_w1", mem[8'h41], 64'hC1);
        chk("t4_w2_untouched", mem[8'h42], 64'hDEAD_BEEF_0000_0042);
        memeq("t4_mem_partial");
        kick(8'h20, 8'h40, 9'd8);
        wait_done(50);
        chk("t4_restart_busy", 64'(busy_cnt), 64'd25);
        memeq("t4_mem_all");

        kick(8'h10, 8'h60, 9'd4);
        repeat (3) @(posedge clk);
        #2;
        src_addr = 8'h00;
        dst_addr = 8'hF0;
        len      = 9'd1;
        start    = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_done(50);
        chk("t5_ignored_busy", 64'(busy_cnt), 64'd13);
        chk("t5_ignored_dst", mem[8'hF0], 64'hDEAD_BEEF_0000_00F0);
        memeq("t5_mem_all");

        pre(8'h30, 64'h1);
        pre(8'h31, 64'h2);
        pre(8'h32, 64'h4);
        kick(8'h30, 8'h90, 9'd3);
        wait_done(50);
        chk("t6_checksum", ck_done, CK_EN ? 64'h7 : 64'h0);
        chk("t6_checksum_hold", checksum, CK_EN ? 64'h7 : 64'h0);
        memeq("t6_mem_all");

        kick(8'h00, 8'h00, 9'd300);
        wait_done(1000);
        chk("t7_busy_cycles", 64'(busy_cnt), 64'd769);
        chk("t7_done_pulses", 64'(done_cnt), 64'd1);
        memeq("t7_mem_all");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
